if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage_fifo.sv | 54 +++++
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: reset vector, bus size codes
// and the layout of one instruction-buffer entry.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } inst_size_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } fetch_entry_t;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// SRAM-like instruction bus between the fetch stage (master) and the
// instruction memory (slave).
interface if_stage_if;

    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        input  inst_rdata, inst_addr_ok, inst_data_ok
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
        output inst_rdata, inst_addr_ok, inst_data_ok
    );

endinterface

// File: rtl/if_stage_fifo.sv
// Small synchronous instruction buffer with flush; entry storage is not reset,
// only the pointers and occupancy count are.
module fetch_fifo
    import if_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one SRAM-like request at a time, buffers
// responses in a 2-entry FIFO for decode, and handles redirects and
// misaligned fetch PCs.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_adel,
    input  logic        id_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      pc_p0;
    logic             vld_p1;
    logic             drop_p1;
    logic [31:0]      pc_p1;
    logic             halt;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;
    logic             buf_room;
    logic             issue_ok;
    logic             accept;
    logic             resp_valid;
    logic             resp_keep;
    logic             adel_push;
    logic             fifo_push;
    logic             fifo_pop;

    // Request gating uses registered state only, so bus handshakes and
    // id_ready never loop back into inst_req.
    assign buf_room       = fifo_count <= CNT_W'(1);
    assign issue_ok       = !vld_p1 && buf_room && !halt && pc_aligned(pc_p0);
    assign bus.inst_req   = issue_ok && !redirect_valid && !rst;
    assign bus.inst_wr    = 1'b0;
    assign bus.inst_size  = SIZE_WORD;
    assign bus.inst_addr  = pc_p0;
    assign bus.inst_wdata = '0;

    assign accept     = bus.inst_req && bus.inst_addr_ok;
    assign resp_valid = bus.inst_data_ok && (vld_p1 || accept);
    assign resp_keep  = resp_valid && !(vld_p1 && drop_p1) && !redirect_valid;
    assign adel_push  = !pc_aligned(pc_p0) && !halt && !vld_p1 && buf_room && !redirect_valid;
    assign fifo_push  = resp_keep || adel_push;
    assign fifo_pop   = if_valid && id_ready;

    // A same-cycle response belongs to the request at pc_p0; a later one to pc_p1.
    always_comb begin
        push_entry.pc   = vld_p1 ? pc_p1 : pc_p0;
        push_entry.inst = adel_push ? '0 : bus.inst_rdata;
        push_entry.adel = adel_push;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign if_valid = !rst && (fifo_count != '0);
    assign if_pc    = if_valid ? fifo_head.pc   : '0;
    assign if_inst  = if_valid ? fifo_head.inst : '0;
    assign if_adel  = if_valid && fifo_head.adel;

    // p0 -> p1: fetch PC advances on acceptance, request tracked until its data returns
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0   <= RESET_PC;
            vld_p1  <= 1'b0;
            drop_p1 <= 1'b0;
            halt    <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc_p0 <= redirect_pc;
                halt  <= 1'b0;
            end else begin
                if (accept)    pc_p0 <= pc_p0 + 32'd4;
                if (adel_push) halt  <= 1'b1;
            end

            if (accept && !bus.inst_data_ok) vld_p1 <= 1'b1;
            else if (vld_p1 && bus.inst_data_ok) vld_p1 <= 1'b0;

            if (redirect_valid && vld_p1 && !bus.inst_data_ok) drop_p1 <= 1'b1;
            else if (vld_p1 && bus.inst_data_ok) drop_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pc_p1 <= pc_p0;
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a latency-configurable bus model plus a
// scoreboard of expected buffer entries compared as decode consumes them.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b1;
    logic        addr_ok_en = 1'b0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    int          lat = 0;
    logic        pend_v = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;

    int          checks = 0;
    int          errors = 0;
    fetch_entry_t sb[$];

    if_stage_if bus ();

    if_stage #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_adel        (if_adel),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    // Memory model: lat==0 answers in the acceptance cycle, otherwise lat cycles later.
    always_comb begin
        bus.inst_addr_ok = addr_ok_en;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'hDEAD_BEEF;
        if (lat == 0) begin
            if (bus.inst_req && addr_ok_en) begin
                bus.inst_data_ok = 1'b1;
                bus.inst_rdata   = word_of(bus.inst_addr);
            end
        end else if (pend_v && pend_cnt == 0) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = word_of(pend_addr);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            pend_v <= 1'b0;
        end else if (pend_v && pend_cnt == 0) begin
            pend_v <= 1'b0;
        end else if (pend_v) begin
            pend_cnt <= pend_cnt - 1;
        end else if (lat != 0 && bus.inst_req && bus.inst_addr_ok) begin
            pend_v    <= 1'b1;
            pend_addr <= bus.inst_addr;
            pend_cnt  <= lat - 1;
        end
    end

    // Scoreboard: push on acceptance, flush on redirect/reset, compare on consume.
    initial begin
        fetch_entry_t exp_e;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
            end else begin
                if (if_valid && id_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected got pc=%h inst=%h adel=%b required none", if_pc, if_inst, if_adel);
                    end else begin
                        exp_e = sb.pop_front();
                        if (if_pc !== exp_e.pc || if_inst !== exp_e.inst || if_adel !== exp_e.adel) begin
                            errors++;
                            $display("FAIL sb_entry got pc=%h inst=%h adel=%b required pc=%h inst=%h adel=%b",
                                     if_pc, if_inst, if_adel, exp_e.pc, exp_e.inst, exp_e.adel);
                        end
                    end
                end
                if (redirect_valid) sb.delete();
                if (bus.inst_req && bus.inst_addr_ok)
                    sb.push_back('{pc: bus.inst_addr, inst: word_of(bus.inst_addr), adel: 1'b0});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; addr_ok_en = 1'b0; lat = 0; id_ready = 1'b1; redirect_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b required 0", bus.inst_req); end
        checks++;
        if (if_valid !== 1'b0 || if_adel !== 1'b0) begin
            errors++; $display("FAIL rst_valid got valid=%b adel=%b required 0 0", if_valid, if_adel);
        end
        checks++;
        if (if_pc !== '0 || if_inst !== '0) begin
            errors++; $display("FAIL rst_pc_inst got pc=%h inst=%h required 0 0", if_pc, if_inst);
        end
        checks++;
        if (bus.inst_wr !== 1'b0 || bus.inst_size !== 2'b10 || bus.inst_wdata !== '0) begin
            errors++; $display("FAIL rst_consts got wr=%b size=%b wdata=%h required 0 10 0",
                               bus.inst_wr, bus.inst_size, bus.inst_wdata);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== RPC) begin
            errors++; $display("FAIL rel_req got req=%b addr=%h required 1 %h", bus.inst_req, bus.inst_addr, RPC);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== RPC) begin
            errors++; $display("FAIL hold_req got req=%b addr=%h required 1 %h", bus.inst_req, bus.inst_addr, RPC);
        end
        tick();
    endtask

    task automatic test_zero_wait();
        addr_ok_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_req !== 1'b1 || bus.inst_addr !== RPC + 32'(4 * i)) begin
                errors++; $display("FAIL zw_addr[%0d] got req=%b addr=%h required 1 %h",
                                   i, bus.inst_req, bus.inst_addr, RPC + 32'(4 * i));
            end
            if (i > 0) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== RPC + 32'(4 * (i - 1))) begin
                    errors++; $display("FAIL zw_ifpc[%0d] got valid=%b pc=%h required 1 %h",
                                       i, if_valid, if_pc, RPC + 32'(4 * (i - 1)));
                end
            end
            tick();
        end
        addr_ok_en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL zw_drain got pending=%0d valid=%b required 0 0", sb.size(), if_valid);
        end
        tick();
    endtask

    task automatic test_latency();
        logic [5:0] exp_req;
        exp_req = 6'b110001;
        lat = 3; addr_ok_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_req !== exp_req[k]) begin
                errors++; $display("FAIL lat_req[%0d] got %b required %b", k, bus.inst_req, exp_req[k]);
            end
            if (k == 0) begin
                checks++;
                if (bus.inst_addr !== RPC + 32'h10) begin
                    errors++; $display("FAIL lat_addr got %h required %h", bus.inst_addr, RPC + 32'h10);
                end
            end
            if (k == 4) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== RPC + 32'h10 || if_inst !== word_of(RPC + 32'h10)) begin
                    errors++; $display("FAIL lat_entry got valid=%b pc=%h inst=%h required 1 %h %h",
                                       if_valid, if_pc, if_inst, RPC + 32'h10, word_of(RPC + 32'h10));
                end
            end
            if (k == 5) begin
                checks++;
                if (if_valid !== 1'b0) begin errors++; $display("FAIL lat_single got valid=%b required 0", if_valid); end
            end
            tick();
            if (k == 0) addr_ok_en = 1'b0;
        end
        lat = 0;
    endtask

    task automatic test_backpressure();
        int n_acc;
        n_acc = 0;
        lat = 0; id_ready = 1'b0; addr_ok_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.inst_req && bus.inst_addr_ok) n_acc++;
            if (k >= 2) begin
                checks++;
                if (bus.inst_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== RPC + 32'h14) begin
                    errors++; $display("FAIL bp_full[%0d] got req=%b valid=%b pc=%h required 0 1 %h",
                                       k, bus.inst_req, if_valid, if_pc, RPC + 32'h14);
                end
            end
            tick();
        end
        checks++;
        if (n_acc != 2) begin errors++; $display("FAIL bp_count got %0d required 2", n_acc); end
        id_ready = 1'b1;
        repeat (4) tick();
        addr_ok_en = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain got pending=%0d valid=%b required 0 0", sb.size(), if_valid);
        end
        tick();
    endtask

    task automatic test_redirect_drop();
        lat = 3; addr_ok_en = 1'b0;
        redirect_valid = 1'b1; redirect_pc = RPC + 32'h8;
        tick();
        redirect_valid = 1'b0; addr_ok_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== RPC + 32'h8) begin
            errors++; $display("FAIL rd_first got req=%b addr=%h required 1 %h", bus.inst_req, bus.inst_addr, RPC + 32'h8);
        end
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_req !== 1'b0 || if_valid !== 1'b0) begin
                errors++; $display("FAIL rd_wait[%0d] got req=%b valid=%b required 0 0", k, bus.inst_req, if_valid);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_1000 || if_valid !== 1'b0) begin
            errors++; $display("FAIL rd_new got req=%b addr=%h valid=%b required 1 80001000 0",
                               bus.inst_req, bus.inst_addr, if_valid);
        end
        tick();
        addr_ok_en = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL rd_drain got pending=%0d valid=%b required 0 0", sb.size(), if_valid);
        end
        tick();
        lat = 0;
    endtask

    task automatic test_misaligned();
        lat = 0; addr_ok_en = 1'b1; id_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
        tick();
        redirect_valid = 1'b0;
        sb.push_back('{pc: 32'h8000_1002, inst: 32'h0, adel: 1'b1});
        @(negedge clk);
        checks++;
        if (bus.inst_req !== 1'b0) begin errors++; $display("FAIL adel_noreq got %b required 0", bus.inst_req); end
        tick();
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || if_adel !== 1'b1 || if_pc !== 32'h8000_1002) begin
            errors++; $display("FAIL adel_entry got valid=%b adel=%b pc=%h required 1 1 80001002",
                               if_valid, if_adel, if_pc);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.inst_req !== 1'b0 || if_valid !== 1'b0) begin
                errors++; $display("FAIL adel_halt[%0d] got req=%b valid=%b required 0 0", k, bus.inst_req, if_valid);
            end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_2000) begin
            errors++; $display("FAIL adel_resume got req=%b addr=%h required 1 80002000", bus.inst_req, bus.inst_addr);
        end
        tick();
    endtask

    task automatic test_rst_midstream();
        id_ready = 1'b0; addr_ok_en = 1'b1; lat = 0;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b1 || bus.inst_req !== 1'b0) begin
            errors++; $display("FAIL mr_full got valid=%b req=%b required 1 0", if_valid, bus.inst_req);
        end
        tick();
        rst = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || bus.inst_req !== 1'b0 || if_pc !== '0) begin
            errors++; $display("FAIL mr_inrst got valid=%b req=%b pc=%h required 0 0 0", if_valid, bus.inst_req, if_pc);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== RPC) begin
            errors++; $display("FAIL mr_release got valid=%b req=%b addr=%h required 0 1 %h",
                               if_valid, bus.inst_req, bus.inst_addr, RPC);
        end
        tick();
        repeat (3) tick();
        addr_ok_en = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL mr_drain got pending=%0d valid=%b required 0 0", sb.size(), if_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_backpressure();
        test_redirect_drop();
        test_misaligned();
        test_rst_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
